// File: rtl/led_scanner.sv
// Knight Rider LED scanner: a single lit head sweeps across N_LEDS outputs with an optional fading trail.
// A synchronised run/stop button toggles the scan; the step rate comes from a run-time programmable prescaler.
module led_scanner #(
    parameter int N_LEDS = 10,
    parameter int DIV_W  = 24,
    parameter int TAIL   = 3,
    parameter int PW     = $clog2(N_LEDS)
) (
    input  logic              CLK,
    input  logic              clr,
    input  logic              run_n,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  period,
    input  logic              tail_en,
    output logic [N_LEDS-1:0] led,
    output logic [PW-1:0]     pos,
    output logic              running,
    output logic              tick
);

    // state   | meaning
    // ST_STOP | scanner halted, prescaler cleared, LEDs dark, head and trail retained
    // ST_RUN  | prescaler counting, head steps on every tick

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } run_e;

    typedef enum logic [1:0] {
        M_BOUNCE  = 2'b00,
        M_WRAP_UP = 2'b01,
        M_WRAP_DN = 2'b10,
        M_HOLD    = 2'b11
    } mode_e;

    localparam int              HN       = (TAIL > 1) ? TAIL - 1 : 1;
    localparam logic [PW-1:0]   POS_LAST = PW'(N_LEDS - 1);
    localparam logic [PW-1:0]   POS_PEN  = PW'(N_LEDS - 2);
    localparam logic [PW-1:0]   POS_ONE  = PW'(1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              sync3_q, sync3_d;
    run_e              run_q, run_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic              dir_q, dir_d;
    logic [PW-1:0]     hist_pos_q [HN];
    logic [PW-1:0]     hist_pos_d [HN];
    logic [HN-1:0]     hist_v_q, hist_v_d;
    logic [N_LEDS-1:0] led_q, led_d;

    logic              press;
    logic              counting;
    logic              step;
    logic [N_LEDS-1:0] lit;

    function automatic logic [N_LEDS-1:0] onehot(input logic [PW-1:0] p);
        logic [N_LEDS-1:0] o;
        o = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            o[i] = (p == PW'(i));
        end
        return o;
    endfunction

    always_comb begin
        sync1_d = run_n;
        sync2_d = sync1_q;
        sync3_d = sync2_q;

        // Only the press (1->0) of the synchronised button toggles, so a held button acts once.
        press = sync3_q & ~sync2_q;
        run_d = run_q;
        if (press) begin
            run_d = (run_q == ST_RUN) ? ST_STOP : ST_RUN;
        end

        // A stop landing on a tick edge must suppress that step, hence the run_d term.
        counting = (run_q == ST_RUN) && (run_d == ST_RUN);

        cnt_d  = '0;
        tick_d = 1'b0;
        if (counting) begin
            if (cnt_q >= period) begin
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        step       = tick_q & counting;
        pos_d      = pos_q;
        dir_d      = dir_q;
        hist_pos_d = hist_pos_q;
        hist_v_d   = hist_v_q;

        if (step) begin
            case (mode_e'(mode))
                M_BOUNCE: begin
                    if (!dir_q) begin
                        if (pos_q == POS_LAST) begin
                            dir_d = 1'b1;
                            pos_d = POS_PEN;
                        end else begin
                            pos_d = pos_q + POS_ONE;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_d = 1'b0;
                            pos_d = POS_ONE;
                        end else begin
                            pos_d = pos_q - POS_ONE;
                        end
                    end
                end
                M_WRAP_UP: begin
                    dir_d = 1'b0;
                    pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
                end
                M_WRAP_DN: begin
                    dir_d = 1'b1;
                    pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_ONE;
                end
                default: begin
                end
            endcase

            if ((mode_e'(mode) != M_HOLD) && (TAIL > 1)) begin
                for (int i = HN - 1; i > 0; i--) begin
                    hist_pos_d[i] = hist_pos_q[i-1];
                    hist_v_d[i]   = hist_v_q[i-1];
                end
                hist_pos_d[0] = pos_q;
                hist_v_d[0]   = 1'b1;
            end
        end

        lit = onehot(pos_d);
        if (tail_en) begin
            for (int i = 0; i < HN; i++) begin
                if (hist_v_d[i]) begin
                    lit = lit | onehot(hist_pos_d[i]);
                end
            end
        end

        // Gating on the current run state delays the LED response one edge behind the toggle.
        led_d = (run_q == ST_RUN) ? lit : '0;
    end

    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            sync3_q  <= 1'b1;
            run_q    <= ST_STOP;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            for (int i = 0; i < HN; i++) begin
                hist_pos_q[i] <= '0;
            end
            hist_v_q <= '0;
            led_q    <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            hist_pos_q <= hist_pos_d;
            hist_v_q   <= hist_v_d;
            led_q      <= led_d;
        end
    end

    assign led     = led_q;
    assign pos     = pos_q;
    assign running = (run_q == ST_RUN);
    assign tick    = tick_q;

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner: vector table for the sweep/trail/mode walk, hand sequences for timing corners.
module tb_led_scanner;

    localparam int N  = 10;
    localparam int DW = 24;
    localparam int TL = 3;

    logic          CLK = 1'b0;
    logic          clr;
    logic          run_n;
    logic [1:0]    mode;
    logic [DW-1:0] period;
    logic          tail_en;
    logic [N-1:0]  led;
    logic [3:0]    pos;
    logic          running;
    logic          tick;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]   mode;
        logic         tail_en;
        logic [3:0]   pos;
        logic [N-1:0] led;
    } vec_t;

    vec_t vt[$];

    always #5 CLK = ~CLK;

    led_scanner #(.N_LEDS(N), .DIV_W(DW), .TAIL(TL)) dut (
        .CLK(CLK), .clr(clr), .run_n(run_n), .mode(mode), .period(period),
        .tail_en(tail_en), .led(led), .pos(pos), .running(running), .tick(tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step_check(input string name, input logic [3:0] ep, input logic [N-1:0] el);
        int n = 0;
        while (tick !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: tick timeout got %b expected 1", name, tick);
        end
        @(posedge CLK);
        @(negedge CLK);
        chk({name, " pos"}, 32'(pos), 32'(ep));
        chk({name, " led"}, 32'(led), 32'(el));
    endtask

    task automatic toggle_run(input logic target, input string name);
        int n = 0;
        run_n = 1'b0;
        @(negedge CLK);
        while (running !== target && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk(name, 32'(running), 32'(target));
        run_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt.push_back('{2'd0, 1'b1, 4'd1, 10'h003});
        vt.push_back('{2'd0, 1'b1, 4'd2, 10'h007});
        vt.push_back('{2'd0, 1'b1, 4'd3, 10'h00E});
        vt.push_back('{2'd0, 1'b1, 4'd4, 10'h01C});
        vt.push_back('{2'd0, 1'b1, 4'd5, 10'h038});
        vt.push_back('{2'd0, 1'b1, 4'd6, 10'h070});
        vt.push_back('{2'd0, 1'b1, 4'd7, 10'h0E0});
        vt.push_back('{2'd0, 1'b1, 4'd8, 10'h1C0});
        vt.push_back('{2'd0, 1'b1, 4'd9, 10'h380});
        vt.push_back('{2'd0, 1'b1, 4'd8, 10'h300});
        vt.push_back('{2'd0, 1'b1, 4'd7, 10'h380});
        vt.push_back('{2'd0, 1'b0, 4'd6, 10'h040});
        vt.push_back('{2'd0, 1'b0, 4'd5, 10'h020});
        vt.push_back('{2'd0, 1'b0, 4'd4, 10'h010});
        vt.push_back('{2'd0, 1'b0, 4'd3, 10'h008});
        vt.push_back('{2'd0, 1'b0, 4'd2, 10'h004});
        vt.push_back('{2'd0, 1'b0, 4'd1, 10'h002});
        vt.push_back('{2'd0, 1'b0, 4'd0, 10'h001});
        vt.push_back('{2'd0, 1'b0, 4'd1, 10'h002});
        vt.push_back('{2'd0, 1'b0, 4'd2, 10'h004});
        vt.push_back('{2'd0, 1'b0, 4'd3, 10'h008});
        vt.push_back('{2'd0, 1'b0, 4'd4, 10'h010});
        vt.push_back('{2'd0, 1'b0, 4'd5, 10'h020});
        vt.push_back('{2'd0, 1'b0, 4'd6, 10'h040});
        vt.push_back('{2'd0, 1'b0, 4'd7, 10'h080});
        vt.push_back('{2'd0, 1'b0, 4'd8, 10'h100});
        vt.push_back('{2'd1, 1'b0, 4'd9, 10'h200});
        vt.push_back('{2'd1, 1'b0, 4'd0, 10'h001});
        vt.push_back('{2'd1, 1'b0, 4'd1, 10'h002});
        vt.push_back('{2'd2, 1'b0, 4'd0, 10'h001});
        vt.push_back('{2'd2, 1'b0, 4'd9, 10'h200});
        vt.push_back('{2'd2, 1'b0, 4'd8, 10'h100});
        vt.push_back('{2'd0, 1'b0, 4'd7, 10'h080});
        vt.push_back('{2'd0, 1'b0, 4'd6, 10'h040});
        vt.push_back('{2'd2, 1'b0, 4'd5, 10'h020});
        vt.push_back('{2'd2, 1'b0, 4'd4, 10'h010});
        vt.push_back('{2'd1, 1'b0, 4'd5, 10'h020});
        vt.push_back('{2'd3, 1'b0, 4'd5, 10'h020});
        vt.push_back('{2'd3, 1'b0, 4'd5, 10'h020});

        // Reset state and button latency with period=3
        clr = 1'b0; run_n = 1'b1; mode = 2'd0; period = DW'(3); tail_en = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst led", 32'(led), 32'h0);
        chk("rst pos", 32'(pos), 32'h0);
        chk("rst running", 32'(running), 32'h0);
        chk("rst tick", 32'(tick), 32'h0);
        clr = 1'b1;
        repeat (2) @(negedge CLK);
        run_n = 1'b0;
        @(negedge CLK); chk("edge1 running", 32'(running), 32'h0);
        @(negedge CLK); chk("edge2 running", 32'(running), 32'h0);
        @(negedge CLK); chk("edge3 running", 32'(running), 32'h1);
        chk("edge3 led", 32'(led), 32'h0);
        @(negedge CLK); chk("edge4 led", 32'(led), 32'h001);
        for (int k = 5; k <= 12; k++) begin
            @(negedge CLK);
            chk($sformatf("tick edge%0d", k), 32'(tick), 32'(k == 7 || k == 11));
            if (k == 8) chk("first step pos", 32'(pos), 32'h1);
            if (k == 5) run_n = 1'b1;
        end
        chk("held button one toggle", 32'(running), 32'h1);

        // Fresh start for the table walk: period=0, trail on at first
        clr = 1'b0;
        @(negedge CLK);
        clr = 1'b1; period = '0; tail_en = 1'b1; mode = 2'd0;
        repeat (2) @(negedge CLK);
        toggle_run(1'b1, "table start running");
        foreach (vt[i]) begin
            mode    = vt[i].mode;
            tail_en = vt[i].tail_en;
            step_check($sformatf("vec%0d", i), vt[i].pos, vt[i].led);
        end

        // Stop while holding at pos 5, then resume upward with period=3
        toggle_run(1'b0, "stop running");
        @(negedge CLK);
        chk("stopped led", 32'(led), 32'h0);
        chk("stopped pos", 32'(pos), 32'h5);
        chk("stopped tick", 32'(tick), 32'h0);
        mode = 2'd0; period = DW'(3);
        repeat (5) @(negedge CLK);
        chk("retained pos", 32'(pos), 32'h5);
        chk("retained led", 32'(led), 32'h0);
        toggle_run(1'b1, "resume running");
        @(negedge CLK);
        chk("resume led", 32'(led), 32'h020);
        step_check("resume step", 4'd6, 10'h040);

        // Stop coinciding with a tick: no step
        @(negedge CLK);
        run_n = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("coincide tick", 32'(tick), 32'h1);
        chk("coincide running", 32'(running), 32'h1);
        @(negedge CLK);
        chk("coincide stop", 32'(running), 32'h0);
        chk("coincide no step pos", 32'(pos), 32'h6);
        chk("coincide led held", 32'(led), 32'h040);
        @(negedge CLK);
        chk("coincide led off", 32'(led), 32'h0);
        run_n = 1'b1;
        repeat (3) @(negedge CLK);

        // Period shrink below the current count
        period = DW'(1000);
        toggle_run(1'b1, "long period running");
        repeat (500) @(negedge CLK);
        chk("no tick before shrink", 32'(tick), 32'h0);
        period = DW'(2);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            chk($sformatf("shrink tick+%0d", k), 32'(tick), 32'(k == 1 || k == 4 || k == 7));
            if (k == 2) chk("shrink step pos", 32'(pos), 32'h7);
        end

        // Asynchronous reset mid-sweep
        #2 clr = 1'b0;
        #1;
        chk("async rst running", 32'(running), 32'h0);
        chk("async rst pos", 32'(pos), 32'h0);
        chk("async rst led", 32'(led), 32'h0);
        chk("async rst tick", 32'(tick), 32'h0);
        @(negedge CLK);
        clr = 1'b1;
        repeat (10) @(negedge CLK);
        chk("post rst running", 32'(running), 32'h0);
        chk("post rst led", 32'(led), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
